mult_seq: RTL

Multi-cycle shift-and-add multiplier sequencer that drives the datapath's shared 32-bit `Add` unit, producing a 64-bit product as HI/LO words for the MULT/MULTU path. It owns no adder of its own. Each step presents operands on `add_in1`/`add_in2` and captures the combinational sum on `add_sum` in the same cycle. It sits between the ID/EX operand registers and the HI/LO register file.

---
 rtl/mult_seq_if.sv | 42 ++++
 rtl/mult_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result bus and shared-adder port of the sequential multiplier.
// The signed_op wire exists only when MULT_SIGNED_EN is defined.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  // request side
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULT_SIGNED_EN
  logic             signed_op;
`endif
  // result side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  // external shared Add unit
  logic [WIDTH-1:0] add_in1;
  logic [WIDTH-1:0] add_in2;
  logic [WIDTH-1:0] add_sum;

`ifdef MULT_SIGNED_EN
  modport slave (
    input  start, a, b, signed_op, add_sum,
    output busy, done, hi, lo, add_in1, add_in2
  );
  modport master (
    output start, a, b, signed_op, add_sum,
    input  busy, done, hi, lo, add_in1, add_in2
  );
`else
  modport slave (
    input  start, a, b, add_sum,
    output busy, done, hi, lo, add_in1, add_in2
  );
  modport master (
    output start, a, b, add_sum,
    input  busy, done, hi, lo, add_in1, add_in2
  );
`endif
endinterface

// File: rtl/mult_seq.sv
// mult_seq: shift-and-add multiplier sequencer (MULT/MULTU) that borrows the
// datapath's 32-bit Add unit. One add per cycle; 32 steps produce {hi,lo}.
// Optional feature macro: MULT_SIGNED_EN (signed_op port, magnitude conversion
// on load, and the NEG_LO/NEG_HI two's-complement fix-up of the product).
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mult_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    NEG_LO = 3'd2,
    NEG_HI = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] add_in1_c, add_in2_c;
  logic             cout;
  logic [WIDTH-1:0] a_ld, b_ld;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic carry_q, carry_d;
  logic neg_ld;

  // Operand magnitudes are formed with a local incrementer so the shared
  // adder is free on the accepting edge; -2^31 maps to 0x80000000 unsigned.
  always_comb begin
    a_ld   = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a) + WIDTH'(1) : bus.a;
    b_ld   = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b) + WIDTH'(1) : bus.b;
    neg_ld = bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end
`else
  // Unsigned-only build: operands load unchanged.
  always_comb begin
    a_ld = bus.a;
    b_ld = bus.b;
  end
`endif

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
`ifdef MULT_SIGNED_EN
      neg_q   <= neg_d;
      carry_q <= carry_d;
`endif
    end
  end

  // Next-state, adder operand decode and register updates.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    add_in1_c = '0;
    add_in2_c = '0;
    cout      = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
    carry_d   = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          mcand_d = a_ld;
          lo_d    = b_ld;
          hi_d    = '0;
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          neg_d   = neg_ld;
`endif
        end
      end
      RUN: begin
        add_in1_c = hi_q;
        add_in2_c = lo_q[0] ? mcand_q : '0;
        // The shared adder drops its carry-out; a wrapped sum is smaller
        // than the operand it started from.
        cout      = (bus.add_sum < hi_q);
        {hi_d, lo_d} = {cout, bus.add_sum, lo_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef MULT_SIGNED_EN
          state_d = neg_q ? NEG_LO : FIN;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG_LO: begin
        add_in1_c = ~lo_q;
        add_in2_c = WIDTH'(1);
        lo_d      = bus.add_sum;
        // ~lo + 1 carries into the high word only when lo was zero.
        carry_d   = (lo_q == '0);
        state_d   = NEG_HI;
      end
      NEG_HI: begin
        add_in1_c = ~hi_q;
        add_in2_c = {{(WIDTH-1){1'b0}}, carry_q};
        hi_d      = bus.add_sum;
        state_d   = FIN;
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.add_in1 = add_in1_c;
  assign bus.add_in2 = add_in2_c;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.done    = (state_q == FIN);
  assign bus.busy    = (state_q == RUN) || (state_q == NEG_LO) || (state_q == NEG_HI);

endmodule
